// File: rtl/mac_array_if.sv
// Term/result bundle between the fetch logic, the MAC lanes and the requantise stage.
// The master drives operands and control; the slave (the MAC array) returns results.
interface mac_array_if #(
    parameter int WIDTH         = 8,
    parameter int LANES         = 4,
    parameter int ACCUMULATIONS = 3,
    parameter int OUT_WIDTH     = 2 * WIDTH + $clog2(ACCUMULATIONS) + 1
);
    localparam int TC_WIDTH = $clog2(ACCUMULATIONS) + 1;

    logic                       clear;
    logic                       in_valid;
    logic [LANES*WIDTH-1:0]     a;
    logic [LANES*WIDTH-1:0]     b;
    logic                       out_valid;
    logic [LANES*OUT_WIDTH-1:0] out;
    logic [LANES-1:0]           overflow;
    logic [TC_WIDTH-1:0]        term_count;

    modport master (
        output clear, in_valid, a, b,
        input  out_valid, out, overflow, term_count
    );

    modport slave (
        input  clear, in_valid, a, b,
        output out_valid, out, overflow, term_count
    );
endinterface

// File: rtl/mac_array.sv
// LANES parallel multiply-accumulate lanes sharing one term counter: a product register
// stage feeds an accumulator that emits a saturated dot product every ACCUMULATIONS terms.
module mac_array #(
    parameter int WIDTH         = 8,
    parameter int LANES         = 4,
    parameter int ACCUMULATIONS = 3,
    parameter int SIGNED        = 0,
    parameter int OUT_WIDTH     = 2 * WIDTH + $clog2(ACCUMULATIONS) + 1
) (
    input  logic        clk,
    input  logic        reset,
    mac_array_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int AW = 2 * WIDTH + $clog2(ACCUMULATIONS) + 1;
    localparam int TW = $clog2(ACCUMULATIONS) + 1;
    localparam int EW = ((AW > OUT_WIDTH) ? AW : OUT_WIDTH) + 1;
    localparam logic [TW-1:0] LAST_TERM = TW'(ACCUMULATIONS - 1);

    logic [TW-1:0]              term_count_q, term_count_d;
    logic [LANES-1:0][PW-1:0]   p_q, p_d;
    logic                       p_valid_q, p_valid_d;
    logic                       p_last_q, p_last_d;
    logic [LANES-1:0][AW-1:0]   acc_q, acc_d;
    logic [LANES*OUT_WIDTH-1:0] out_q, out_d;
    logic                       out_valid_q, out_valid_d;
    logic [LANES-1:0]           overflow_q, overflow_d;
    logic [AW-1:0]              sum;
    logic [OUT_WIDTH:0]         sat_res;

    // Doubling the operand width before multiplying makes the low 2*WIDTH bits of the
    // product correct for both signed and unsigned operands.
    function automatic logic [PW-1:0] extend_operand(input logic [WIDTH-1:0] x);
        return {{WIDTH{(SIGNED != 0) & x[WIDTH-1]}}, x};
    endfunction

    // Returns {overflow, clamped value}; widening to EW keeps the slices legal even
    // when OUT_WIDTH is at least as wide as the accumulator.
    function automatic logic [OUT_WIDTH:0] saturate(input logic [AW-1:0] s);
        logic [EW-1:0]        se;
        logic                 ovf;
        logic [OUT_WIDTH-1:0] v;
        se = {{(EW-AW){(SIGNED != 0) & s[AW-1]}}, s};
        if (SIGNED != 0) begin
            ovf = !((&se[EW-1:OUT_WIDTH-1]) | ~(|se[EW-1:OUT_WIDTH-1]));
            if (ovf) begin
                v = se[EW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end else begin
                v = se[OUT_WIDTH-1:0];
            end
        end else begin
            ovf = |se[EW-1:OUT_WIDTH];
            v   = ovf ? '1 : se[OUT_WIDTH-1:0];
        end
        return {ovf, v};
    endfunction

    always_comb begin
        term_count_d = term_count_q;
        p_d          = p_q;
        p_valid_d    = 1'b0;
        p_last_d     = p_last_q;
        acc_d        = acc_q;
        out_d        = out_q;
        out_valid_d  = 1'b0;
        overflow_d   = overflow_q;
        sum          = '0;
        sat_res      = '0;

        // Clear beats both the incoming term and a finished sum already in stage 2.
        if (bus.clear) begin
            term_count_d = '0;
            acc_d        = '0;
            p_last_d     = 1'b0;
        end else begin
            if (bus.in_valid) begin
                p_valid_d    = 1'b1;
                p_last_d     = (term_count_q == LAST_TERM);
                term_count_d = (term_count_q == LAST_TERM) ? '0 : term_count_q + TW'(1);
                for (int i = 0; i < LANES; i++) begin
                    p_d[i] = extend_operand(bus.a[i*WIDTH +: WIDTH]) *
                             extend_operand(bus.b[i*WIDTH +: WIDTH]);
                end
            end
            if (p_valid_q) begin
                for (int i = 0; i < LANES; i++) begin
                    sum = acc_q[i] + {{(AW-PW){(SIGNED != 0) & p_q[i][PW-1]}}, p_q[i]};
                    if (p_last_q) begin
                        sat_res                          = saturate(sum);
                        out_d[i*OUT_WIDTH +: OUT_WIDTH] = sat_res[OUT_WIDTH-1:0];
                        overflow_d[i]                    = sat_res[OUT_WIDTH];
                        acc_d[i]                         = '0;
                    end else begin
                        acc_d[i] = sum;
                    end
                end
                out_valid_d = p_last_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            term_count_q <= '0;
            p_q          <= '0;
            p_valid_q    <= 1'b0;
            p_last_q     <= 1'b0;
            acc_q        <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= '0;
        end else begin
            term_count_q <= term_count_d;
            p_q          <= p_d;
            p_valid_q    <= p_valid_d;
            p_last_q     <= p_last_d;
            acc_q        <= acc_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out        = out_q;
    assign bus.overflow   = overflow_q;
    assign bus.term_count = term_count_q;
endmodule
